// File: rtl/cnn_layer_seq_if.sv
// cnn_layer_seq_if: handshake bundle between the layer sequencer and its
// surroundings (UART front end, layer chain, result transmitter).
//   start/abort/err_clr : frame control from the front end
//   layer_rdy/tx_done   : completion pulses from layers and transmitter
//   layer_strt          : one-hot launch pulses to the layers
//   cur_layer/bsy/done/err : sequencer status
//   prof_sel/prof_cnt   : per-layer cycle profile readback (CNN_SEQ_PROFILE_EN)
// Modports: master = environment side, slave = sequencer side.
interface cnn_layer_seq_if #(
  parameter int unsigned N_LAYERS = 6
);
  localparam int unsigned IDX_W = $clog2(N_LAYERS);

  logic                start;
  logic                abort;
  logic                err_clr;
  logic [N_LAYERS-1:0] layer_rdy;
  logic                tx_done;
  logic [N_LAYERS-1:0] layer_strt;
  logic [IDX_W-1:0]    cur_layer;
  logic                bsy;
  logic                done;
  logic                err;
`ifdef CNN_SEQ_PROFILE_EN
  logic [IDX_W-1:0]    prof_sel;
  logic [31:0]         prof_cnt;

  modport master (
    output start, abort, err_clr, layer_rdy, tx_done, prof_sel,
    input  layer_strt, cur_layer, bsy, done, err, prof_cnt
  );
  modport slave (
    input  start, abort, err_clr, layer_rdy, tx_done, prof_sel,
    output layer_strt, cur_layer, bsy, done, err, prof_cnt
  );
`else
  modport master (
    output start, abort, err_clr, layer_rdy, tx_done,
    input  layer_strt, cur_layer, bsy, done, err
  );
  modport slave (
    input  start, abort, err_clr, layer_rdy, tx_done,
    output layer_strt, cur_layer, bsy, done, err
  );
`endif
endinterface

// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq: central sequencer for the conv/max/conv/max/dense/out layer
// pipeline. Launches each layer with a one-cycle strt pulse, waits for its
// rdy, then waits for tx_done and pulses done. A per-layer watchdog moves the
// sequencer to a sticky error state when a layer (or the transmitter) stalls.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - cnn_layer_seq_if.slave (control in, strt/status out)
// Optional feature macro: CNN_SEQ_PROFILE_EN adds per-layer 32-bit cycle
// counters readable through bus.prof_sel / bus.prof_cnt.
module cnn_layer_seq #(
  parameter int unsigned N_LAYERS = 6,
  parameter int unsigned TO_W     = 20,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  cnn_layer_seq_if.slave bus
);
  localparam int unsigned      IDX_W    = $clog2(N_LAYERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);
  localparam logic [TO_W-1:0]  WD_LIMIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  WD_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_XMIT, S_FIN, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cur_layer_q, cur_layer_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [N_LAYERS-1:0] layer_strt_q, layer_strt_d;
  logic                bsy_q, bsy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cur_rdy_c;
  logic [TO_W-1:0]     wd_inc_c;

  assign cur_rdy_c = bus.layer_rdy[cur_layer_q];
  assign wd_inc_c  = (wd_q == WD_MAX) ? wd_q : wd_q + TO_W'(1);

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cur_layer_d  = cur_layer_q;
    wd_d         = wd_q;
    err_d        = err_q;
    layer_strt_d = '0;
    bsy_d        = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // err_clr is honoured here too, so an abort out of ERR cannot lock
        // the sequencer with err stuck high.
        if (bus.err_clr) err_d = 1'b0;
        if (bus.start && !err_q) begin
          state_d     = S_LAUNCH;
          cur_layer_d = '0;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_inc_c;
        // Progress is checked before timeout so a tie advances.
        if (cur_rdy_c) begin
          if (cur_layer_q == LAST_IDX) begin
            state_d = S_XMIT;
            wd_d    = '0;
          end else begin
            state_d     = S_LAUNCH;
            cur_layer_d = cur_layer_q + IDX_W'(1);
          end
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_XMIT: begin
        wd_d = wd_inc_c;
        if (bus.tx_done) begin
          state_d = S_FIN;
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (bus.err_clr) begin
          state_d     = S_IDLE;
          err_d       = 1'b0;
          cur_layer_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything except reset and leaves err as it was.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cur_layer_d = '0;
      wd_d        = '0;
      err_d       = err_q;
    end

    // strt is issued the cycle after LAUNCH, unless LAUNCH was aborted.
    if ((state_q == S_LAUNCH) && (state_d == S_WAIT)) begin
      layer_strt_d[cur_layer_q] = 1'b1;
    end
    bsy_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT) ||
             (state_d == S_XMIT)   || (state_d == S_FIN);
    done_d = (state_d == S_FIN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_layer_q  <= '0;
      wd_q         <= '0;
      layer_strt_q <= '0;
      bsy_q        <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_layer_q  <= cur_layer_d;
      wd_q         <= wd_d;
      layer_strt_q <= layer_strt_d;
      bsy_q        <= bsy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.layer_strt = layer_strt_q;
  assign bus.cur_layer  = cur_layer_q;
  assign bus.bsy        = bsy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

`ifdef CNN_SEQ_PROFILE_EN
  logic [31:0] prof_q [N_LAYERS];
  logic [31:0] prof_d [N_LAYERS];

  // Per-layer cycle counters: clear on launch, count while waiting, saturate
  always_comb begin
    for (int i = 0; i < int'(N_LAYERS); i++) begin
      prof_d[i] = prof_q[i];
      if (cur_layer_q == IDX_W'(i)) begin
        if (state_q == S_LAUNCH) begin
          prof_d[i] = '0;
        end else if ((state_q == S_WAIT) && (prof_q[i] != '1)) begin
          prof_d[i] = prof_q[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_LAYERS); i++) prof_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_LAYERS); i++) prof_q[i] <= prof_d[i];
    end
  end

  assign bus.prof_cnt = (32'(bus.prof_sel) < N_LAYERS) ? prof_q[bus.prof_sel] : '0;
`endif

endmodule

// File: tb/tb_cnn_layer_seq.sv
// tb_cnn_layer_seq: directed bench for cnn_layer_seq. Inputs are driven 1ns
// after the rising edge and outputs are sampled at the same point, so each
// step(n) lands just after the n-th edge. The timeout is shortened so stall
// and tie scenarios stay short.
module tb_cnn_layer_seq;
  localparam int unsigned N = 6;
`ifdef CNN_SEQ_PROFILE_EN
  localparam int unsigned TO = 64;
`else
  localparam int unsigned TO = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_layer_seq_if #(.N_LAYERS(N)) bus ();

  cnn_layer_seq #(.N_LAYERS(N), .TO_W(20), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned done_cnt = 0;
  int unsigned d0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse rdy of layer i for one edge
  task automatic ack(input int i);
    bus.layer_rdy = N'(1 << i);
    step(1);
    bus.layer_rdy = '0;
  endtask

  // Entry: just after the edge that raised strt[0]
  task automatic start_frame();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("launch_bsy", 32'(bus.bsy), 32'd1);
    check("launch_no_strt", 32'(bus.layer_strt), 32'd0);
    step(1);
  endtask

  // Entry: just after strt[i] rose. Exit: just after strt[i+1] rose, or in XMIT.
  task automatic run_layer(input int i, input int dly);
    check($sformatf("strt_l%0d", i), 32'(bus.layer_strt), 32'd1 << i);
    check($sformatf("cur_l%0d", i), 32'(bus.cur_layer), 32'(i));
    step(dly - 1);
    check($sformatf("wait_l%0d", i), {30'd0, bus.bsy, |bus.layer_strt}, 32'd2);
    ack(i);
    if (i < int'(N) - 1) begin
      check($sformatf("adv_cur_l%0d", i), 32'(bus.cur_layer), 32'(i + 1));
      check($sformatf("adv_strt_l%0d", i), 32'(bus.layer_strt), 32'd0);
      step(1);
    end else begin
      check("xmit_bsy", 32'(bus.bsy), 32'd1);
    end
  endtask

  // Entry: in XMIT. tx_done 5 cycles after the last rdy.
  task automatic finish_frame(input int unsigned d_start);
    step(4);
    bus.tx_done = 1'b1;
    step(1);
    bus.tx_done = 1'b0;
    check("fin_done", {30'd0, bus.done, bus.bsy}, 32'd3);
    step(1);
    check("idle_after_fin", {30'd0, bus.done, bus.bsy}, 32'd0);
    check("done_once", done_cnt - d_start, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.err_clr   = 1'b0;
    bus.layer_rdy = '0;
    bus.tx_done   = 1'b0;
`ifdef CNN_SEQ_PROFILE_EN
    bus.prof_sel  = '0;
`endif
    step(3);
    check("rst_strt", 32'(bus.layer_strt), 32'd0);
    check("rst_cur", 32'(bus.cur_layer), 32'd0);
    check("rst_flags", {29'd0, bus.bsy, bus.done, bus.err}, 32'd0);
    rst = 1'b0;
    step(1);

    // Normal frame
    d0 = done_cnt;
    start_frame();
    for (int i = 0; i < int'(N); i++) run_layer(i, 10);
    finish_frame(d0);

    // Stray rdy and start while busy during layer 1
    d0 = done_cnt;
    start_frame();
    run_layer(0, 10);
    step(3);
    bus.layer_rdy = N'(1 << 3);
    bus.start     = 1'b1;
    step(1);
    bus.layer_rdy = '0;
    bus.start     = 1'b0;
    check("stray_cur", 32'(bus.cur_layer), 32'd1);
    check("stray_strt", 32'(bus.layer_strt), 32'd0);
    step(2);
    check("stray_no_l2", {30'd0, bus.bsy, |bus.layer_strt}, 32'd2);
    ack(1);
    check("stray_adv_cur", 32'(bus.cur_layer), 32'd2);
    step(1);
    for (int i = 2; i < int'(N); i++) run_layer(i, 10);
    finish_frame(d0);

    // Timeout on layer 2
    start_frame();
    run_layer(0, 10);
    run_layer(1, 10);
    check("to_strt_l2", 32'(bus.layer_strt), 32'd4);
    step(TO - 1);
    check("to_pre", {30'd0, bus.err, bus.bsy}, 32'd1);
    step(1);
    check("to_err", {30'd0, bus.err, bus.bsy}, 32'd2);
    check("to_cur", 32'(bus.cur_layer), 32'd2);
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    check("to_start_ign", {29'd0, bus.err, bus.bsy, |bus.layer_strt}, 32'd4);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    check("clr_err", {30'd0, bus.err, bus.bsy}, 32'd0);
    check("clr_cur", 32'(bus.cur_layer), 32'd0);

    // Tie on layer 0, then abort during layer 4
    d0 = done_cnt;
    start_frame();
    check("tie_strt_l0", 32'(bus.layer_strt), 32'd1);
    step(TO - 1);
    ack(0);
    check("tie_no_err", {30'd0, bus.err, bus.bsy}, 32'd1);
    check("tie_cur", 32'(bus.cur_layer), 32'd1);
    step(1);
    for (int i = 1; i < 4; i++) run_layer(i, 10);
    check("ab_strt_l4", 32'(bus.layer_strt), 32'd16);
    step(3);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("ab_idle", {29'd0, bus.bsy, bus.done, bus.err}, 32'd0);
    step(3);
    check("ab_quiet", 32'(bus.layer_strt), 32'd0);
    check("ab_no_done", done_cnt - d0, 32'd0);

    // Reset in XMIT, then a full frame
    start_frame();
    for (int i = 0; i < int'(N); i++) run_layer(i, 10);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_flags", {29'd0, bus.bsy, bus.done, bus.err}, 32'd0);
    check("mid_rst_cur", 32'(bus.cur_layer), 32'd0);
    check("mid_rst_strt", 32'(bus.layer_strt), 32'd0);
    d0 = done_cnt;
    start_frame();
    for (int i = 0; i < int'(N); i++) run_layer(i, 10);
    finish_frame(d0);

`ifdef CNN_SEQ_PROFILE_EN
    // Layer 1 rdy 37 cycles after its strt
    d0 = done_cnt;
    start_frame();
    run_layer(0, 10);
    run_layer(1, 37);
    bus.prof_sel = 3'd1;
    #1;
    check("prof_l1", bus.prof_cnt, 32'd37);
    bus.prof_sel = 3'd0;
    #1;
    check("prof_l0", bus.prof_cnt, 32'd10);
    for (int i = 2; i < int'(N); i++) run_layer(i, 10);
    finish_frame(d0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
